fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 19 +
 rtl/fetch_sequencer_if.sv | 31 +++
 rtl/fetch_sequencer.sv | 106 ++++++++++
 tb/tb_fetch_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch-unit definitions: FSM state encoding, instruction size and fetch exception causes.
package fetch_sequencer_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [3:0] EXC_INSTR_ADDR_MISALIGNED = 4'd0;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StDrain,
        StOut
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory, redirect and IF-stage signals of the fetch sequencer; master is the sequencer side.
interface fetch_sequencer_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exception;
    logic [3:0]  out_exception_cause;
    logic        busy;

    modport master (
        output mem_req, mem_addr, out_valid, out_pc, out_instr, out_exception,
               out_exception_cause, busy,
        input  mem_gnt, mem_rvalid, mem_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  mem_req, mem_addr, out_valid, out_pc, out_instr, out_exception,
               out_exception_cause, busy,
        output mem_gnt, mem_rvalid, mem_rdata, redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer: PC register, fetch FSM and registered IF output.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_sequencer_if.master  bus
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic         booted_q;
    logic         out_valid_q;
    logic [31:0]  out_pc_q;
    logic [31:0]  out_instr_q;
    logic         out_exc_q;
    logic [3:0]   out_cause_q;

    logic pc_misaligned;
    logic mem_req;
    logic req_granted;

    assign pc_misaligned = is_misaligned(pc_q);
    // A misaligned PC never reaches memory; REQ turns it into an exception word instead.
    assign mem_req       = (state_q == StReq) && !pc_misaligned;
    assign req_granted   = mem_req && bus.mem_gnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pc_q        <= RESET_VECTOR;
            booted_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
            out_exc_q   <= 1'b0;
            out_cause_q <= '0;
        end else if (bus.redirect_valid) begin
            pc_q     <= bus.redirect_pc;
            booted_q <= 1'b1;
            case (state_q)
                StIdle, StOut: begin
                    state_q     <= StReq;
                    out_valid_q <= 1'b0;
                end
                StReq:           state_q <= req_granted ? StDrain : StIdle;
                StWait, StDrain: state_q <= bus.mem_rvalid ? StReq : StDrain;
                default:         state_q <= StIdle;
            endcase
        end else begin
            case (state_q)
                StIdle: begin
                    // Hold IDLE one extra cycle after reset so the first request
                    // appears on the second edge after release.
                    booted_q <= 1'b1;
                    if (booted_q) state_q <= StReq;
                end
                StReq: begin
                    if (pc_misaligned) begin
                        out_valid_q <= 1'b1;
                        out_pc_q    <= pc_q;
                        out_instr_q <= '0;
                        out_exc_q   <= 1'b1;
                        out_cause_q <= EXC_INSTR_ADDR_MISALIGNED;
                        state_q     <= StOut;
                    end else if (bus.mem_gnt) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (bus.mem_rvalid) begin
                        out_valid_q <= 1'b1;
                        out_pc_q    <= pc_q;
                        out_instr_q <= bus.mem_rdata;
                        out_exc_q   <= 1'b0;
                        out_cause_q <= '0;
                        pc_q        <= pc_q + 32'(INSTR_BYTES);
                        state_q     <= StOut;
                    end
                end
                StDrain: begin
                    if (bus.mem_rvalid) state_q <= StReq;
                end
                StOut: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StReq;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.mem_req             = mem_req;
    assign bus.mem_addr            = pc_q;
    assign bus.busy                = (state_q == StWait) || (state_q == StDrain);
    assign bus.out_valid           = out_valid_q;
    assign bus.out_pc              = out_pc_q;
    assign bus.out_instr           = out_instr_q;
    assign bus.out_exception       = out_exc_q;
    assign bus.out_exception_cause = out_cause_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized checks of fetch_sequencer against a word-stream reference model.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // ---------------- main DUT and memory model ----------------
    fetch_sequencer_if bus ();
    fetch_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic        ready = 1'b0, redir = 1'b0, gnt_en = 1'b1, poison = 1'b0, rogue = 1'b0;
    logic [31:0] rpc = '0;
    int          lat_cfg = 2;
    logic        outst = 1'b0;
    int          cnt = 0;
    logic [31:0] maddr = '0;
    logic        m_rvalid;

    assign m_rvalid           = outst && (cnt == 1);
    assign bus.mem_gnt        = gnt_en;
    assign bus.mem_rvalid     = m_rvalid | rogue;
    assign bus.mem_rdata      = (rogue || poison) ? 32'hDEAD_BEEF : mem_fn(maddr);
    assign bus.out_ready      = ready;
    assign bus.redirect_valid = redir;
    assign bus.redirect_pc    = rpc;

    // Response arrives lat_cfg cycles after the grant cycle; memory shares rst_n.
    always @(posedge clk) begin
        if (!rst_n) outst <= 1'b0;
        else if (bus.mem_req && bus.mem_gnt) begin
            outst <= 1'b1;
            cnt   <= lat_cfg;
            maddr <= bus.mem_addr;
        end else if (outst) begin
            if (cnt == 1) outst <= 1'b0;
            else cnt <= cnt - 1;
        end
    end

    // Reference model: the sequence of words the IF stage must accept.
    logic [31:0] exp_pc = '0, st_pc, st_instr;
    logic        stall_q = 1'b0;
    int          n_acc = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc  = 32'h0;
            stall_q = 1'b0;
        end else begin
            check_eq("busy_vs_outstanding", bus.busy, outst);
            if (bus.mem_req) begin
                check_eq("req_addr", bus.mem_addr, exp_pc);
                check_eq("req_aligned_idle", {bus.mem_addr[1:0], bus.busy}, 3'b000);
            end
            if (bus.out_valid) check_eq("valid_no_req", bus.mem_req, 1'b0);
            if (stall_q) begin
                check_eq("stall_valid", bus.out_valid, 1'b1);
                check_eq("stall_pc", bus.out_pc, st_pc);
                check_eq("stall_instr", bus.out_instr, st_instr);
            end
            if (bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
                check_eq("acc_pc", bus.out_pc, exp_pc);
                check_eq("acc_exc", bus.out_exception, exp_pc[1:0] != 2'b00);
                check_eq("acc_instr", bus.out_instr, (exp_pc[1:0] != 2'b00) ? 32'h0 : mem_fn(exp_pc));
                check_eq("acc_cause", bus.out_exception_cause, 4'd0);
                if (exp_pc[1:0] == 2'b00) exp_pc = exp_pc + 32'd4;
                n_acc++;
            end
            if (bus.redirect_valid) exp_pc = bus.redirect_pc;
            stall_q  = bus.out_valid && !bus.out_ready && !bus.redirect_valid;
            st_pc    = bus.out_pc;
            st_instr = bus.out_instr;
        end
    end

    // ---------------- wrap-around DUT ----------------
    fetch_sequencer_if bus2 ();
    fetch_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    logic rv2 = 1'b0;
    logic [31:0] q2_addr[$], q2_pc[$];
    logic        q2_exc[$];
    assign bus2.mem_gnt        = 1'b1;
    assign bus2.mem_rvalid     = rv2;
    assign bus2.mem_rdata      = 32'h1234_5678;
    assign bus2.out_ready      = 1'b1;
    assign bus2.redirect_valid = 1'b0;
    assign bus2.redirect_pc    = 32'h0;
    always @(posedge clk) rv2 <= rst_n && bus2.mem_req;
    always @(negedge clk) begin
        if (rst_n && bus2.mem_req && q2_addr.size() < 4) q2_addr.push_back(bus2.mem_addr);
        if (rst_n && bus2.out_valid && q2_pc.size() < 4) begin
            q2_pc.push_back(bus2.out_pc);
            q2_exc.push_back(bus2.out_exception);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.out_valid) return;
        end
        check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_busy(input logic level, input string tag);
        for (int i = 0; i < 64; i++) begin
            if (bus.busy == level) return;
            step();
        end
        check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    int t_word[3];
    logic [31:0] hold_pc, hold_instr;

    initial begin
        repeat (3) step();
        check_eq("rst_flags", {bus.mem_req, bus.out_valid, bus.out_exception, bus.busy}, 4'b0);
        check_eq("rst_cause", bus.out_exception_cause, 4'd0);
        check_eq("rst_out_pc", bus.out_pc, 32'h0);
        check_eq("rst_out_instr", bus.out_instr, 32'h0);

        rst_n = 1'b1;
        step();
        check_eq("boot_edge1_req", bus.mem_req, 1'b0);
        step();
        check_eq("boot_edge2_req", bus.mem_req, 1'b1);
        check_eq("boot_addr", bus.mem_addr, 32'h0);

        // One empty cycle between grant and response: a word every 4 cycles.
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid("seq_word");
            t_word[k] = cyc;
            check_eq("seq_pc", bus.out_pc, 32'(4 * k));
            step();
        end
        check_eq("seq_period01", t_word[1] - t_word[0], 32'd4);
        check_eq("seq_period12", t_word[2] - t_word[1], 32'd4);

        // Back-pressure: word held, no request issued.
        ready = 1'b0;
        wait_valid("stall_word");
        hold_pc    = bus.out_pc;
        hold_instr = bus.out_instr;
        repeat (5) begin
            @(negedge clk);
            check_eq("bp_valid", bus.out_valid, 1'b1);
            check_eq("bp_pc", bus.out_pc, hold_pc);
            check_eq("bp_instr", bus.out_instr, hold_instr);
            check_eq("bp_no_req", bus.mem_req, 1'b0);
        end
        @(posedge clk);
        #1;
        ready   = 1'b1;
        lat_cfg = 3;

        // Redirect in WAIT; stale DEADBEEF response lands two cycles later.
        step();
        wait_busy(1'b1, "wait_enter");
        redir  = 1'b1;
        rpc    = 32'h100;
        poison = 1'b1;
        step();
        redir = 1'b0;
        wait_busy(1'b0, "drain_done");
        poison = 1'b0;
        wait_valid("after_drain");
        check_eq("drain_pc", bus.out_pc, 32'h100);
        check_eq("drain_instr", bus.out_instr, mem_fn(32'h100));

        // Misaligned redirect in OUT becomes an exception word.
        @(posedge clk);
        #1;
        ready = 1'b0;
        wait_valid("out_word");
        @(posedge clk);
        #1;
        redir = 1'b1;
        rpc   = 32'h202;
        step();
        redir = 1'b0;
        check_eq("mis_valid_clr", bus.out_valid, 1'b0);
        check_eq("mis_no_req0", bus.mem_req, 1'b0);
        step();
        check_eq("mis_valid", bus.out_valid, 1'b1);
        check_eq("mis_exc", bus.out_exception, 1'b1);
        check_eq("mis_cause", bus.out_exception_cause, 4'd0);
        check_eq("mis_pc", bus.out_pc, 32'h202);
        check_eq("mis_instr", bus.out_instr, 32'h0);
        check_eq("mis_no_req1", bus.mem_req, 1'b0);
        redir = 1'b1;
        rpc   = 32'h40;
        ready = 1'b1;
        step();
        redir = 1'b0;

        // Reset while a response is outstanding, then a rogue late response.
        wait_busy(1'b1, "rst_wait");
        rst_n = 1'b0;
        step();
        check_eq("rstw_flags", {bus.mem_req, bus.out_valid, bus.out_exception, bus.busy}, 4'b0);
        check_eq("rstw_pc", bus.out_pc, 32'h0);
        check_eq("rstw_instr", bus.out_instr, 32'h0);
        check_eq("rstw_cause", bus.out_exception_cause, 4'd0);
        rst_n = 1'b1;
        rogue = 1'b1;
        step();
        rogue = 1'b0;
        check_eq("rogue_ignored", {bus.busy, bus.out_valid}, 2'b00);
        wait_valid("restart");
        check_eq("restart_pc", bus.out_pc, 32'h0);
        check_eq("restart_instr", bus.out_instr, mem_fn(32'h0));

        // Wrap-around instance.
        check_eq("wrap_nreq", q2_addr.size() >= 2 && q2_pc.size() >= 2, 1'b1);
        if (q2_addr.size() >= 2 && q2_pc.size() >= 2) begin
            check_eq("wrap_addr0", q2_addr[0], 32'hFFFF_FFFC);
            check_eq("wrap_addr1", q2_addr[1], 32'h0);
            check_eq("wrap_pc1", q2_pc[1], 32'h0);
            check_eq("wrap_exc", {q2_exc[0], q2_exc[1]}, 2'b00);
        end

        // Randomized traffic checked by the reference model.
        n_acc = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            redir   = !redir && ($urandom % 12 == 0);
            rpc     = 32'($urandom_range(0, 255)) << 2;
            if ($urandom % 4 == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            ready   = ($urandom % 4) != 0;
            gnt_en  = ($urandom % 4) != 0;
            lat_cfg = $urandom_range(1, 3);
        end
        check_eq("rand_progress", n_acc > 100, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
